// File: rtl/dmem_arbiter.sv
// Round-robin sharer of the single-port data memory between the MEM stage (port 0)
// and the debug/loader port (port 1). Define DMEM_ADDR_CHECK_EN to reject illegal addresses.
module dmem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_BASE    = 1024,
    parameter int MEM_WORDS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_r_en,
    input  logic        cpu_w_en,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_dataIn,
    output logic [31:0] cpu_dataOut,
    output logic        cpu_ready,
    input  logic        dbg_r_en,
    input  logic        dbg_w_en,
    input  logic [31:0] dbg_address,
    input  logic [31:0] dbg_dataIn,
    output logic [31:0] dbg_dataOut,
    output logic        dbg_ready,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut,
    output logic        busy,
    output logic        addr_err
);
    localparam logic [1:0]  IDLE       = 2'd0;
    localparam logic [1:0]  ACCESS     = 2'd1;
    localparam logic [1:0]  DONE       = 2'd2;
    localparam logic [31:0] ADDR_LO    = 32'(MEM_BASE);
    localparam logic [31:0] ADDR_HI    = 32'(MEM_BASE + 4 * MEM_WORDS - 4);
    localparam logic [7:0]  COUNT_INIT = 8'(WAIT_CYCLES - 1);

    logic [1:0]  state_reg;
    logic [7:0]  count_reg;
    logic        last_grant_reg;
    logic        grant_reg;
    logic        write_reg;
    logic        err_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic [1:0]       req;
    logic [1:0]       wr;
    logic [1:0]       ready;
    logic [1:0][31:0] addr_in;
    logic [1:0][31:0] data_in;
    logic [1:0][31:0] dout;

    assign req     = {dbg_r_en | dbg_w_en, cpu_r_en | cpu_w_en};
    assign wr      = {dbg_w_en, cpu_w_en};
    assign addr_in = {dbg_address, cpu_address};
    assign data_in = {dbg_dataIn, cpu_dataIn};

    // Tie goes to the port that did not win last time.
    logic        grant_id;
    logic [31:0] sel_addr;
    logic        addr_legal;
    logic        addr_ok;

    assign grant_id   = (&req) ? ~last_grant_reg : req[1];
    assign sel_addr   = addr_in[grant_id];
    assign addr_legal = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI) && (sel_addr[1:0] == 2'b00);

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_ok = addr_legal;
`else
    logic unused_addr_legal;
    assign unused_addr_legal = addr_legal;
    assign addr_ok = 1'b1;
`endif

    logic in_access;
    logic last_access;

    assign in_access   = (state_reg == ACCESS);
    assign last_access = in_access && (count_reg == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            write_reg      <= 1'b0;
            err_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_reg      <= grant_id;
                        last_grant_reg <= grant_id;
                        write_reg      <= wr[grant_id];
                        addr_reg       <= sel_addr;
                        wdata_reg      <= data_in[grant_id];
                        count_reg      <= COUNT_INIT;
                        err_reg        <= ~addr_ok;
                        state_reg      <= addr_ok ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    if (count_reg == 8'd0) begin
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg - 8'd1;
                    end
                end
                DONE: begin
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] dout_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (last_access && !write_reg && (grant_reg == 1'(gi))) begin
                    dout_reg <= mem_dataOut;
                end
            end
            assign dout[gi]  = dout_reg;
            assign ready[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign cpu_dataOut = dout[0];
    assign dbg_dataOut = dout[1];
    assign cpu_ready   = ready[0];
    assign dbg_ready   = ready[1];

    // A write landing on a reset cycle is dropped: the memory is being reset too.
    assign mem_r_en    = in_access && !write_reg;
    assign mem_w_en    = last_access && write_reg && !rst;
    assign mem_address = in_access ? addr_reg : '0;
    assign mem_dataIn  = in_access ? wdata_reg : '0;

    assign busy     = (state_reg != IDLE);
    assign addr_err = (state_reg == DONE) && err_reg;
endmodule
